dco_freq_counter: RTL and testbench
===================================

// Module: dco_freq_counter
// PURPOSE
//  Downstream measurement stage for the DCO: counts rising edges of the DCO output over a gate
//  window of GATE_CYCLES system clocks and reports the count, i.e. frequency in edges per window.
//  Lets software or a tuning loop read DCO frequency per dco_code value without a scope.
//  dco_in is asynchronous to clk; it must stay below clk/2 for an exact count.
// PARAMETERS
//  GATE_CYCLES  256  gate window length in clk cycles (>=2)
//  COUNT_W      16   width of edge counter and count_out
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous active-low reset
//  ena          in   1        design enable; low aborts any window
//  dco_in       in   1        DCO output, asynchronous
//  start        in   1        single-shot measurement request (level sampled per clk)
//  continuous   in   1        1 = back-to-back windows with no start needed
//  count_out    out  COUNT_W  last completed window result
//  count_valid  out  1        one-cycle pulse when count_out updates
//  overflow     out  1        last result saturated
//  busy         out  1        window in progress
// BEHAVIOUR
//  - Reset (async, rst_n=0): sync flops, edge flop, counters, count_out, count_valid,
//    overflow, busy all 0; FSM -> IDLE. Reset mid-window discards the window; no valid.
//  - Input path: 2-flop synchronizer, then a third flop; rise = s2 & ~s3 (one clk pulse per edge).
//    The 2-3 cycle detection latency is not compensated.
//  - FSM IDLE/COUNT. IDLE: if ena & (start|continuous) at edge k -> COUNT, edge_cnt=0,
//    gate_cnt=GATE_CYCLES-1, busy=1.
//  - COUNT: at each edge k+1..k+GATE_CYCLES, edge_cnt += rise, saturating at 2^COUNT_W-1
//    (sticky ovf flag set on an increment attempt at max). gate_cnt decrements each cycle.
//  - Terminal cycle (gate_cnt==0): count_out <= edge_cnt+rise (saturated), overflow <= ovf,
//    count_valid=1 for exactly one cycle after edge k+GATE_CYCLES. A rise in the terminal
//    cycle belongs to the current window.
//  - Continuous mode: at the terminal edge, if continuous & ena, restart in the same edge
//    (edge_cnt=0, gate reload). Windows are gapless; valids are exactly GATE_CYCLES apart.
//    Otherwise the FSM goes to IDLE and busy=0.
//  - start while busy is ignored (no queuing). start held high in single-shot mode retriggers
//    one cycle after each completion.
//  - ena low in COUNT: next edge -> IDLE, busy=0, window discarded. count_out and overflow hold;
//    no valid is produced.
//  - count_out and overflow hold their values between valids.
// CONFIGURATION
//  DCO_FREQ_AVG_EN defined:
//  - A 4-window accumulator (COUNT_W+2 bits) sums the window results.
//  - count_out = sum>>2 (truncated), count_valid fires on every 4th completed window only.
//  - overflow = OR of the 4 window ovf flags.
//  - Abort, ena low, or reset clears the accumulator and the phase counter.
//  Not defined: each window result is reported directly and no accumulator is built.
// TESTING
//  1 GATE=256, dco_in period 8 clk, start pulse -> busy 256 cycles, count_out=32, one valid pulse.
//  2 dco_in held 0 (then held 1), start -> count_out=0, overflow=0.
//  3 dco_in toggled every clk (rise every 2 clk) -> count_out=128.
//  4 COUNT_W=4, period 4 -> count_out=15, overflow=1. Next window at period 8 (32 edges, still
//    saturates) -> count_out=15, overflow=1.
//  5 continuous=1, period 8 -> valids exactly 256 cycles apart, each 32. Drop ena mid-window ->
//    busy=0 next cycle, no valid, count_out holds 32.
//  6 rst_n low mid-window -> all outputs 0 asynchronously, no valid after release.
//  7 (AVG_EN) continuous, periods 8,8,4,4 per window -> single valid after window 4, count_out=48.

Source files
------------

// File: rtl/dco_freq_counter.sv
// Gated edge counter for the DCO output: counts synchronized rising edges of dco_in over
// GATE_CYCLES clocks. Optional 4-window averaging is built when DCO_FREQ_AVG_EN is defined.
module dco_freq_counter #(
   parameter int GATE_CYCLES = 256,
   parameter int COUNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               dco_in,
   input  logic               start,
   input  logic               continuous,
   output logic [COUNT_W-1:0] count_out,
   output logic               count_valid,
   output logic               overflow,
   output logic               busy
);

   localparam int GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GATE_W-1:0]  GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic {IDLE, COUNT} state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic                r_s1, r_s2, r_s3;
   logic [COUNT_W-1:0]  r_edgeCnt;
   logic [GATE_W-1:0]   r_gateCnt;
   logic                r_ovf;
   logic                w_rise;
   logic                w_satHit;
   logic [COUNT_W-1:0]  w_edgeNext;
   logic                w_ovfNext;
   logic                w_terminal;
   logic                w_load;

   // Two-flop synchronizer plus a history flop for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= dco_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_rise     = r_s2 & ~r_s3;
   assign w_satHit   = w_rise & (r_edgeCnt == CNT_MAX);
   assign w_edgeNext = w_satHit ? r_edgeCnt : r_edgeCnt + COUNT_W'(w_rise);
   assign w_ovfNext  = r_ovf | w_satHit;
   assign w_terminal = (r_state == COUNT) & ena & (r_gateCnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:  if (ena & (start | continuous)) w_nextState = COUNT;
         COUNT: begin
            if (!ena)                          w_nextState = IDLE;
            else if (w_terminal & ~continuous) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // A window (re)starts either from IDLE or gaplessly at the terminal edge in continuous mode.
   always_comb begin
      busy   = (r_state == COUNT);
      w_load = ((r_state == IDLE) & ena & (start | continuous)) | (w_terminal & continuous);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_edgeCnt <= '0;
         r_gateCnt <= '0;
         r_ovf     <= 1'b0;
      end else if (w_load) begin
         r_edgeCnt <= '0;
         r_gateCnt <= GATE_LOAD;
         r_ovf     <= 1'b0;
      end else if (r_state == COUNT) begin
         r_edgeCnt <= w_edgeNext;
         r_gateCnt <= r_gateCnt - 1'b1;
         r_ovf     <= w_ovfNext;
      end
   end

`ifdef DCO_FREQ_AVG_EN
   logic [COUNT_W+1:0] r_acc;
   logic [1:0]         r_phase;
   logic               r_ovfAcc;
   logic [COUNT_W+1:0] w_accSum;

   assign w_accSum = r_acc + (COUNT_W+2)'(w_edgeNext);

   // Only every fourth completed window publishes the averaged result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_phase     <= '0;
         r_ovfAcc    <= 1'b0;
         count_out   <= '0;
         overflow    <= 1'b0;
         count_valid <= 1'b0;
      end else begin
         count_valid <= 1'b0;
         if (!ena) begin
            r_acc    <= '0;
            r_phase  <= '0;
            r_ovfAcc <= 1'b0;
         end else if (w_terminal) begin
            if (r_phase == 2'd3) begin
               count_out   <= w_accSum[COUNT_W+1:2];
               overflow    <= r_ovfAcc | w_ovfNext;
               count_valid <= 1'b1;
               r_acc       <= '0;
               r_phase     <= '0;
               r_ovfAcc    <= 1'b0;
            end else begin
               r_acc    <= w_accSum;
               r_phase  <= r_phase + 1'b1;
               r_ovfAcc <= r_ovfAcc | w_ovfNext;
            end
         end
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_out   <= '0;
         overflow    <= 1'b0;
         count_valid <= 1'b0;
      end else begin
         count_valid <= w_terminal;
         if (w_terminal) begin
            count_out <= w_edgeNext;
            overflow  <= w_ovfNext;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dco_freq_counter.sv
// Self-checking bench for dco_freq_counter: a 16-bit and a 4-bit instance share stimulus.
// Default build checks per-window results; DCO_FREQ_AVG_EN build checks 4-window averaging.
module tb_dco_freq_counter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic        dco_in = 1'b0;
   logic        start = 1'b0;
   logic        continuous = 1'b0;
   logic [15:0] count_out;
   logic        count_valid, overflow, busy;
   logic [3:0]  smallCount;
   logic        smallValid, smallOvf, smallBusy;

   int          nChecks = 0;
   int          nFails = 0;
   int          dcoPeriod = 0;
   int          dcoPhase = 0;
   logic        dcoLevel = 1'b0;

   typedef struct {
      string name;
      int    period;
      logic  level;
      int    expCount;
      logic  expOvf;
      int    expSmall;
      logic  expSmallOvf;
   } vec_t;

   vec_t vecs[8];

   dco_freq_counter #(.GATE_CYCLES(256), .COUNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .dco_in(dco_in), .start(start),
      .continuous(continuous), .count_out(count_out), .count_valid(count_valid),
      .overflow(overflow), .busy(busy)
   );

   dco_freq_counter #(.GATE_CYCLES(256), .COUNT_W(4)) dutSmall (
      .clk(clk), .rst_n(rst_n), .ena(ena), .dco_in(dco_in), .start(start),
      .continuous(continuous), .count_out(smallCount), .count_valid(smallValid),
      .overflow(smallOvf), .busy(smallBusy)
   );

   always #5 clk = ~clk;

   // DCO model: period 0 means hold dcoLevel, otherwise high for the first half of each period.
   always @(posedge clk) begin
      #1;
      if (dcoPeriod == 0) begin
         dco_in = dcoLevel;
         dcoPhase = 0;
      end else begin
         dcoPhase = (dcoPhase + 1) % dcoPeriod;
         dco_in = (dcoPhase < dcoPeriod / 2);
      end
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Pulses start for one cycle and observes a fixed 400-cycle span afterwards.
   task automatic applyStimulus(output int busyCycles, output int valids, output int smallValids);
      busyCycles = 0;
      valids = 0;
      smallValids = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (busy) busyCycles++;
         if (count_valid) valids++;
         if (smallValid) smallValids++;
         @(negedge clk);
      end
   endtask

   initial begin
      int busyCycles, valids, smallValids;
      int lastValid, gap, nValid;

      vecs[0] = '{"p8",    8, 1'b0,  32, 1'b0, 15, 1'b1};
      vecs[1] = '{"hold0", 0, 1'b0,   0, 1'b0,  0, 1'b0};
      vecs[2] = '{"hold1", 0, 1'b1,   0, 1'b0,  0, 1'b0};
      vecs[3] = '{"p2",    2, 1'b0, 128, 1'b0, 15, 1'b1};
      vecs[4] = '{"p4",    4, 1'b0,  64, 1'b0, 15, 1'b1};
      vecs[5] = '{"p8b",   8, 1'b0,  32, 1'b0, 15, 1'b1};
      vecs[6] = '{"p16",  16, 1'b0,  16, 1'b0, 15, 1'b1};
      vecs[7] = '{"p32",  32, 1'b0,   8, 1'b0,  8, 1'b0};

      waitCycles(3);
      checkOutput("reset_count", count_out, 0);
      checkOutput("reset_valid", count_valid, 0);
      checkOutput("reset_ovf", overflow, 0);
      checkOutput("reset_busy", busy, 0);
      rst_n = 1'b1;
      ena = 1'b1;
      waitCycles(2);

`ifndef DCO_FREQ_AVG_EN
      for (int v = 0; v < 8; v++) begin
         dcoPeriod = vecs[v].period;
         dcoLevel = vecs[v].level;
         waitCycles(20);
         applyStimulus(busyCycles, valids, smallValids);
         checkOutput({vecs[v].name, "_count"}, count_out, vecs[v].expCount);
         checkOutput({vecs[v].name, "_ovf"}, overflow, vecs[v].expOvf);
         checkOutput({vecs[v].name, "_busy"}, busyCycles, 256);
         checkOutput({vecs[v].name, "_valids"}, valids, 1);
         checkOutput({vecs[v].name, "_small_count"}, smallCount, vecs[v].expSmall);
         checkOutput({vecs[v].name, "_small_ovf"}, smallOvf, vecs[v].expSmallOvf);
         checkOutput({vecs[v].name, "_small_valids"}, smallValids, 1);
      end

      // Continuous mode: gapless windows, valids exactly one gate apart.
      dcoPeriod = 8;
      waitCycles(20);
      continuous = 1'b1;
      nValid = 0;
      lastValid = 0;
      for (int i = 0; i < 1200 && nValid < 3; i++) begin
         @(negedge clk);
         if (count_valid) begin
            checkOutput("cont_count", count_out, 32);
            if (nValid > 0) begin
               gap = i - lastValid;
               checkOutput("cont_gap", gap, 256);
            end
            lastValid = i;
            nValid++;
         end
      end
      checkOutput("cont_nvalid", nValid, 3);
      checkOutput("cont_busy", busy, 1);

      // Dropping ena mid-window aborts it without a result.
      waitCycles(100);
      ena = 1'b0;
      @(negedge clk);
      checkOutput("abort_busy", busy, 0);
      continuous = 1'b0;
      valids = 0;
      for (int i = 0; i < 300; i++) begin
         if (count_valid) valids++;
         @(negedge clk);
      end
      checkOutput("abort_valids", valids, 0);
      checkOutput("abort_hold_count", count_out, 32);
      ena = 1'b1;
`else
      // Four-window averaging in continuous mode: one valid per four windows.
      dcoPeriod = 8;
      waitCycles(20);
      continuous = 1'b1;
      nValid = 0;
      lastValid = 0;
      for (int i = 0; i < 4000 && nValid < 2; i++) begin
         @(negedge clk);
         if (count_valid) begin
            checkOutput("avg_count", count_out, 32);
            checkOutput("avg_ovf", overflow, 0);
            checkOutput("avg_small_ovf", smallOvf, 1);
            if (nValid > 0) begin
               gap = i - lastValid;
               checkOutput("avg_gap", gap, 1024);
            end
            lastValid = i;
            nValid++;
         end
      end
      checkOutput("avg_nvalid", nValid, 2);
      continuous = 1'b0;
      waitCycles(300);
`endif

      // Asynchronous reset in the middle of a window.
      dcoPeriod = 8;
      waitCycles(20);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitCycles(100);
      checkOutput("pre_reset_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_count", count_out, 0);
      checkOutput("rst_ovf", overflow, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_small_ovf", smallOvf, 0);
      @(negedge clk);
      rst_n = 1'b1;
      valids = 0;
      busyCycles = 0;
      for (int i = 0; i < 300; i++) begin
         if (count_valid) valids++;
         if (busy) busyCycles++;
         @(negedge clk);
      end
      checkOutput("post_rst_valids", valids, 0);
      checkOutput("post_rst_busy", busyCycles, 0);
      checkOutput("post_rst_count", count_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
